// File: rtl/shift_seq_ctrl.sv
// Sequencer for a serial-in shift register: takes a word, shifts it in MSB-first and reads Q back to verify it.
// Optional build macro SHIFT_RETRY_EN: on a failed check, re-send the word once and report RETRIED.
module shift_seq_ctrl #(
  parameter int WIDTH = 9,
  parameter int LW    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             SDATA,
  output logic             SHIFT_EN,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             DONE,
  output logic             MATCH,
`ifdef SHIFT_RETRY_EN
  output logic             RETRIED,
`endif
  output logic [LW-1:0]    LEAD
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               ready_q, ready_d;
  logic               sdata_q, sdata_d;
  logic               shift_en_q, shift_en_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic [LW-1:0]      lead_q, lead_d;
  logic [LW-1:0]      lead_c;
  logic               run_c;
`ifdef SHIFT_RETRY_EN
  logic               pass_q, pass_d;
  logic               retried_q, retried_d;
`endif

  // Leading ones of Q_IN from the MSB down; the count stops at the first zero.
  always_comb begin
    lead_c = '0;
    run_c  = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      run_c = run_c & Q_IN[i];
      if (run_c) lead_c = lead_c + LW'(1);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    match_d = match_q;
    lead_d  = lead_q;
`ifdef SHIFT_RETRY_EN
    pass_d    = pass_q;
    retried_d = retried_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          word_d  = DIN;
          idx_d   = LAST_IDX;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q == '0) state_d = S_CHECK;
        else             idx_d   = idx_q - IW'(1);
      end
      S_CHECK: begin
        match_d = (Q_IN == word_q);
        lead_d  = lead_c;
        state_d = S_DONE;
`ifdef SHIFT_RETRY_EN
        if ((Q_IN != word_q) && !pass_q) begin
          pass_d  = 1'b1;
          idx_d   = LAST_IDX;
          state_d = S_SHIFT;
        end else begin
          retried_d = pass_q;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef SHIFT_RETRY_EN
        pass_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    ready_d    = (state_d == S_IDLE);
    shift_en_d = (state_d == S_SHIFT);
    sdata_d    = shift_en_d ? word_d[idx_d] : 1'b0;
    done_d     = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      sdata_q    <= 1'b0;
      shift_en_q <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      lead_q     <= '0;
`ifdef SHIFT_RETRY_EN
      pass_q     <= 1'b0;
      retried_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      sdata_q    <= sdata_d;
      shift_en_q <= shift_en_d;
      done_q     <= done_d;
      match_q    <= match_d;
      lead_q     <= lead_d;
`ifdef SHIFT_RETRY_EN
      pass_q     <= pass_d;
      retried_q  <= retried_d;
`endif
    end
  end

  assign READY    = ready_q;
  assign SDATA    = sdata_q;
  assign SHIFT_EN = shift_en_q;
  assign DONE     = done_q;
  assign MATCH    = match_q;
  assign LEAD     = lead_q;
`ifdef SHIFT_RETRY_EN
  assign RETRIED  = retried_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 9-bit shift register on the serial side.
// Honours SHIFT_RETRY_EN when the design is built with it.
module tb_shift_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       LOAD;
  logic [8:0] DIN;
  logic       READY;
  logic       SDATA;
  logic       SHIFT_EN;
  logic [8:0] Q_IN;
  logic       DONE;
  logic       MATCH;
  logic [3:0] LEAD;
`ifdef SHIFT_RETRY_EN
  logic       RETRIED;
`endif

  shift_seq_ctrl #(.WIDTH(9), .LW(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .LOAD     (LOAD),
    .DIN      (DIN),
    .READY    (READY),
    .SDATA    (SDATA),
    .SHIFT_EN (SHIFT_EN),
    .Q_IN     (Q_IN),
    .DONE     (DONE),
    .MATCH    (MATCH),
`ifdef SHIFT_RETRY_EN
    .RETRIED  (RETRIED),
`endif
    .LEAD     (LEAD)
  );

  always #5 CLK = ~CLK;

  // Shift register model: shifts left, new bit enters bit 0, never reset by the controller.
  logic [8:0] sr = '0;
  logic       fault;
  always @(posedge CLK) if (SHIFT_EN) sr <= {sr[7:0], SDATA};
  assign Q_IN = fault ? 9'h000 : sr;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-transfer observations, cycle k = the interval after accept edge k-1.
  int          sen_cnt, done_cnt, done_cyc;
  logic [17:0] sbits;
  logic        m_done, r_done, ready_after, m_c1;
  logic [3:0]  l_done, l_c1;

  task automatic run_xfer(input logic [8:0] din, input int pulse_at, input int rst_at);
    sen_cnt = 0; done_cnt = 0; done_cyc = -10; sbits = '0;
    m_done = 1'b0; r_done = 1'b0; l_done = '0; ready_after = 1'b0;
    LOAD = 1'b1;
    DIN  = din;
    @(posedge CLK);
    @(negedge CLK);
    DIN = ~din;
    for (int k = 1; k <= 24; k++) begin
      LOAD = (k == pulse_at);
      if (k == pulse_at) DIN = 9'h0AA;
      if (k == 1) begin
        m_c1 = MATCH;
        l_c1 = LEAD;
      end
      if (SHIFT_EN) begin
        sen_cnt++;
        sbits = {sbits[16:0], SDATA};
      end
      if (DONE) begin
        done_cnt++;
        done_cyc = k;
        m_done   = MATCH;
        l_done   = LEAD;
`ifdef SHIFT_RETRY_EN
        r_done   = RETRIED;
`endif
      end
      if (k == done_cyc + 1) ready_after = READY;
      if (k == rst_at) begin
        RESET = 1'b1;
        #1;
        check("rst_shift_en_drop", 32'(SHIFT_EN), 32'd0);
        check("rst_ready_rise", 32'(READY), 32'd1);
        #2;
        RESET = 1'b0;
      end
      @(negedge CLK);
    end
    LOAD = 1'b0;
  endtask

  initial begin
    int acc2, dcnt;
    RESET = 1'b1;
    LOAD  = 1'b0;
    DIN   = '0;
    fault = 1'b0;
    @(negedge CLK);
    check("reset_ready", 32'(READY), 32'd1);
    check("reset_shift_en", 32'(SHIFT_EN), 32'd0);
    check("reset_sdata", 32'(SDATA), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_match", 32'(MATCH), 32'd0);
    check("reset_lead", 32'(LEAD), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // All-ones word.
    run_xfer(9'h1FF, -1, -1);
    check("ones_sen_cnt", 32'(sen_cnt), 32'd9);
    check("ones_sbits", 32'(sbits[8:0]), 32'h1FF);
    check("ones_done_cyc", 32'(done_cyc), 32'd11);
    check("ones_done_cnt", 32'(done_cnt), 32'd1);
    check("ones_match", 32'(m_done), 32'd1);
    check("ones_lead", 32'(l_done), 32'd9);
    check("ones_ready_after", 32'(ready_after), 32'd1);
`ifdef SHIFT_RETRY_EN
    check("ones_retried", 32'(r_done), 32'd0);
`endif

    // Three leading ones; results from the previous transfer must still be held at cycle 1.
    run_xfer(9'b111000000, -1, -1);
    check("held_match", 32'(m_c1), 32'd1);
    check("held_lead", 32'(l_c1), 32'd9);
    check("lead3_sbits", 32'(sbits[8:0]), 32'h1C0);
    check("lead3_match", 32'(m_done), 32'd1);
    check("lead3_lead", 32'(l_done), 32'd3);
    check("lead3_ready_after", 32'(ready_after), 32'd1);

    // Faulty register stuck at zero.
    fault = 1'b1;
    run_xfer(9'b011111111, -1, -1);
    fault = 1'b0;
    check("fault_match", 32'(m_done), 32'd0);
    check("fault_lead", 32'(l_done), 32'd0);
    check("fault_done_cnt", 32'(done_cnt), 32'd1);
`ifdef SHIFT_RETRY_EN
    check("fault_sen_cnt", 32'(sen_cnt), 32'd18);
    check("fault_sbits", 32'(sbits), 32'h1FEFF);
    check("fault_done_cyc", 32'(done_cyc), 32'd21);
    check("fault_retried", 32'(r_done), 32'd1);
`else
    check("fault_sen_cnt", 32'(sen_cnt), 32'd9);
    check("fault_done_cyc", 32'(done_cyc), 32'd11);
`endif

    // LOAD pulse during an active transfer is ignored.
    run_xfer(9'h1F0, 4, -1);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_sen_cnt", 32'(sen_cnt), 32'd9);
    check("busy_match", 32'(m_done), 32'd1);
    check("busy_lead", 32'(l_done), 32'd5);

    // Reset in the 5th shift cycle aborts without DONE.
    run_xfer(9'h1FF, -1, 5);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    check("abort_sen_cnt", 32'(sen_cnt), 32'd5);
    check("abort_lead_cleared", 32'(LEAD), 32'd0);

    run_xfer(9'h1FF, -1, -1);
    check("recover_match", 32'(m_done), 32'd1);
    check("recover_lead", 32'(l_done), 32'd9);
    check("recover_done_cyc", 32'(done_cyc), 32'd11);

    // LOAD held high: back-to-back accepts.
    acc2 = -1;
    dcnt = 0;
    LOAD = 1'b1;
    DIN  = 9'h1FF;
    @(posedge CLK);
    @(negedge CLK);
    for (int k = 1; k <= 26; k++) begin
      if (READY && acc2 < 0) begin
        acc2 = k;
        DIN  = 9'h0FF;
      end else if (acc2 > 0 && k == acc2 + 1) begin
        LOAD = 1'b0;
      end
      if (DONE) begin
        dcnt++;
        if (dcnt == 1) begin
          check("b2b_done1_cyc", 32'(k), 32'd11);
          check("b2b_done1_lead", 32'(LEAD), 32'd9);
        end else begin
          check("b2b_done2_cyc", 32'(k), 32'd23);
          check("b2b_done2_lead", 32'(LEAD), 32'd0);
          check("b2b_done2_match", 32'(MATCH), 32'd1);
        end
      end
      @(negedge CLK);
    end
    LOAD = 1'b0;
    check("b2b_accept_gap", 32'(acc2), 32'd12);
    check("b2b_done_cnt", 32'(dcnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
